// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, register-file commit with read bypass,
// forwarding tuple, one-cycle PC redirect and retired-instruction counter.
module wb_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             valid_in,
   input  logic             flush,
   input  logic             stall,
   input  logic             wr_in,
   input  logic             rm_in,
   input  logic [1:0]       rd_in,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] ac_in,
   input  logic             taken_in,
   input  logic [WIDTH-1:0] jump_in,
   input  logic [1:0]       rs_a,
   input  logic [1:0]       rs_b,
   output logic [WIDTH-1:0] ra_val,
   output logic [WIDTH-1:0] rb_val,
   output logic             fwd_valid,
   output logic [1:0]       fwd_rd,
   output logic [WIDTH-1:0] fwd_val,
   output logic             pc_load,
   output logic [WIDTH-1:0] pc_target,
   output logic [7:0]       retired
);

   localparam int NREGS = 4;

   logic             validQ;
   logic             wrQ;
   logic             rmQ;
   logic             takenQ;
   logic [1:0]       rdQ;
   logic [WIDTH-1:0] dataQ;
   logic [WIDTH-1:0] acQ;
   logic [WIDTH-1:0] jumpQ;
   logic [WIDTH-1:0] regs [NREGS];
   logic [7:0]       retiredQ;
   logic [WIDTH-1:0] wbVal;
   logic             wbWrite;

   assign wbVal   = rmQ ? dataQ : acQ;
   assign wbWrite = validQ && wrQ;

   // Flush and stall both leave a bubble; the other fields simply hold.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         validQ <= 1'b0;
         wrQ    <= 1'b0;
         rmQ    <= 1'b0;
         takenQ <= 1'b0;
         rdQ    <= '0;
         dataQ  <= '0;
         acQ    <= '0;
         jumpQ  <= '0;
      end else if (flush || stall) begin
         validQ <= 1'b0;
      end else begin
         validQ <= valid_in;
         wrQ    <= wr_in;
         rmQ    <= rm_in;
         takenQ <= taken_in;
         rdQ    <= rd_in;
         dataQ  <= data_in;
         acQ    <= ac_in;
         jumpQ  <= jump_in;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wbWrite) begin
         regs[rdQ] <= wbVal;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         retiredQ <= 8'd0;
      end else if (validQ) begin
         retiredQ <= retiredQ + 8'd1;
      end
   end

   assign retired = retiredQ;

   assign ra_val = (wbWrite && rs_a == rdQ) ? wbVal : regs[rs_a];
   assign rb_val = (wbWrite && rs_b == rdQ) ? wbVal : regs[rs_b];

   assign fwd_valid = wbWrite;
   assign fwd_rd    = wbWrite ? rdQ : 2'd0;
   assign fwd_val   = wbWrite ? wbVal : '0;

   assign pc_load   = validQ && takenQ;
   assign pc_target = pc_load ? jumpQ : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: scoreboard of expected stage outputs plus a
// small register-file/counter model checked after every clock edge.
module tb_wb_stage;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       valid_in, flush, stall, wr_in, rm_in, taken_in;
   logic [1:0] rd_in, rs_a, rs_b;
   logic [7:0] data_in, ac_in, jump_in;
   logic [7:0] ra_val, rb_val, fwd_val, pc_target, retired;
   logic       fwd_valid, pc_load;
   logic [1:0] fwd_rd;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       fv;
      logic [1:0] frd;
      logic [7:0] fval;
      logic       pl;
      logic [7:0] pt;
   } exp_t;

   exp_t sb[$];

   // Bench model of the stage contents and the committed state.
   logic       stV, stWr, stTaken;
   logic [1:0] stRd;
   logic [7:0] stVal, stJump;
   logic [7:0] mRegs [4];
   logic [7:0] mRet;

   wb_stage #(.WIDTH(8)) dut (
      .clock(clock), .reset_n(reset_n), .valid_in(valid_in),
      .flush(flush), .stall(stall), .wr_in(wr_in), .rm_in(rm_in),
      .rd_in(rd_in), .data_in(data_in), .ac_in(ac_in),
      .taken_in(taken_in), .jump_in(jump_in), .rs_a(rs_a), .rs_b(rs_b),
      .ra_val(ra_val), .rb_val(rb_val), .fwd_valid(fwd_valid),
      .fwd_rd(fwd_rd), .fwd_val(fwd_val), .pc_load(pc_load),
      .pc_target(pc_target), .retired(retired)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] expRead(input logic [1:0] a);
      if (stV && stWr && a == stRd) return stVal;
      return mRegs[a];
   endfunction

   task automatic modelReset();
      stV = 0; stWr = 0; stTaken = 0; stRd = 0; stVal = 0; stJump = 0;
      for (int i = 0; i < 4; i++) mRegs[i] = 8'h00;
      mRet = 8'h00;
   endtask

   task automatic checkZero(input string tag);
      chk({tag, ".fwd_valid"}, {7'd0, fwd_valid}, 8'h00);
      chk({tag, ".fwd_rd"}, {6'd0, fwd_rd}, 8'h00);
      chk({tag, ".fwd_val"}, fwd_val, 8'h00);
      chk({tag, ".pc_load"}, {7'd0, pc_load}, 8'h00);
      chk({tag, ".pc_target"}, pc_target, 8'h00);
      chk({tag, ".retired"}, retired, 8'h00);
      chk({tag, ".ra_val"}, ra_val, 8'h00);
      chk({tag, ".rb_val"}, rb_val, 8'h00);
   endtask

   // Called at a falling edge: drive, clock once, compare at next falling edge.
   task automatic step(input string tag, input logic v, input logic wr,
                       input logic rm, input logic [1:0] rd,
                       input logic [7:0] dat, input logic [7:0] ac,
                       input logic tk, input logic [7:0] jmp,
                       input logic fl, input logic st,
                       input logic [1:0] rsb);
      exp_t e;
      valid_in = v; wr_in = wr; rm_in = rm; rd_in = rd;
      data_in = dat; ac_in = ac; taken_in = tk; jump_in = jmp;
      flush = fl; stall = st; rs_a = rd; rs_b = rsb;
      if (stV) begin
         if (stWr) mRegs[stRd] = stVal;
         mRet = mRet + 8'd1;
      end
      stV = v && !(fl || st);
      stWr = wr; stRd = rd; stVal = rm ? dat : ac;
      stTaken = tk; stJump = jmp;
      e.fv = stV && stWr;
      e.frd = e.fv ? stRd : 2'd0;
      e.fval = e.fv ? stVal : 8'h00;
      e.pl = stV && stTaken;
      e.pt = e.pl ? stJump : 8'h00;
      sb.push_back(e);
      @(posedge clock);
      @(negedge clock);
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 8'h01, 8'h00);
      end else begin
         e = sb.pop_front();
         chk({tag, ".fwd_valid"}, {7'd0, fwd_valid}, {7'd0, e.fv});
         chk({tag, ".fwd_rd"}, {6'd0, fwd_rd}, {6'd0, e.frd});
         chk({tag, ".fwd_val"}, fwd_val, e.fval);
         chk({tag, ".pc_load"}, {7'd0, pc_load}, {7'd0, e.pl});
         chk({tag, ".pc_target"}, pc_target, e.pt);
      end
      chk({tag, ".retired"}, retired, mRet);
      chk({tag, ".ra_val"}, ra_val, expRead(rd));
      chk({tag, ".rb_val"}, rb_val, expRead(rsb));
   endtask

   task automatic bubble(input string tag, input logic [1:0] rsb);
      step(tag, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, rsb);
   endtask

   initial begin
      modelReset();
      reset_n = 1'b0;
      valid_in = 1; wr_in = 1; rm_in = 1; rd_in = 2'd3;
      data_in = 8'hAA; ac_in = 8'h55; taken_in = 1; jump_in = 8'h99;
      flush = 0; stall = 0; rs_a = 2'd1; rs_b = 2'd2;
      @(posedge clock);
      @(negedge clock);
      checkZero("reset0");
      reset_n = 1'b1;

      step("alu", 1, 1, 0, 2'd2, 8'h00, 8'h5A, 0, 8'h00, 0, 0, 2'd2);
      chk("alu.fwd_val_const", fwd_val, 8'h5A);
      bubble("alu_commit", 2'd2);
      chk("alu.reg2_const", rb_val, 8'h5A);
      chk("alu.retired_const", retired, 8'h01);

      step("load", 1, 1, 1, 2'd1, 8'hC3, 8'h11, 0, 8'h00, 0, 0, 2'd2);
      chk("load.fwd_val_const", fwd_val, 8'hC3);
      bubble("load_commit", 2'd1);
      chk("load.reg1_const", rb_val, 8'hC3);

      step("jump", 1, 0, 0, 2'd0, 8'h00, 8'hEE, 1, 8'h40, 0, 0, 2'd0);
      chk("jump.pc_target_const", pc_target, 8'h40);
      bubble("jump_after", 2'd0);
      chk("jump.pc_load_off", {7'd0, pc_load}, 8'h00);
      chk("jump.reg0_const", rb_val, 8'h00);
      chk("jump.retired_const", retired, 8'h03);

      step("stall", 1, 1, 0, 2'd3, 8'h00, 8'h77, 0, 8'h00, 0, 1, 2'd3);
      bubble("stall_after", 2'd3);
      chk("stall.reg3_const", rb_val, 8'h00);
      step("flush", 1, 1, 0, 2'd3, 8'h00, 8'h77, 0, 8'h00, 1, 0, 2'd3);
      bubble("flush_after", 2'd3);
      step("both", 1, 1, 0, 2'd3, 8'h00, 8'h77, 0, 8'h00, 1, 1, 2'd3);
      bubble("both_after", 2'd3);
      chk("both.retired_const", retired, 8'h03);
      step("plain", 1, 1, 0, 2'd3, 8'h00, 8'h77, 0, 8'h00, 0, 0, 2'd3);
      bubble("plain_after", 2'd3);
      chk("plain.reg3_const", rb_val, 8'h77);

      step("b2b1", 1, 1, 0, 2'd0, 8'h00, 8'h01, 0, 8'h00, 0, 0, 2'd0);
      step("b2b2", 1, 1, 0, 2'd0, 8'h00, 8'h02, 0, 8'h00, 0, 0, 2'd0);
      step("b2b3", 1, 1, 1, 2'd0, 8'h03, 8'hF0, 0, 8'h00, 0, 0, 2'd0);
      bubble("b2b_after", 2'd0);
      chk("b2b.reg0_const", rb_val, 8'h03);

      // A commit in flight must survive a stall at the same edge.
      step("inflight", 1, 1, 0, 2'd1, 8'h00, 8'h3C, 0, 8'h00, 0, 0, 2'd1);
      step("inflight_st", 1, 1, 0, 2'd1, 8'h00, 8'hFF, 0, 8'h00, 0, 1, 2'd1);
      chk("inflight.reg1_const", rb_val, 8'h3C);

      for (int i = 0; i < 24; i++) begin
         step("rand", 1'($urandom), 1'($urandom), 1'($urandom),
              2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
              8'($urandom), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0), 2'($urandom));
      end

      step("pre_rst", 1, 1, 0, 2'd2, 8'h00, 8'h9D, 1, 8'h21, 0, 0, 2'd3);
      #2 reset_n = 1'b0;
      #1 checkZero("async_rst");
      modelReset();
      @(negedge clock);
      reset_n = 1'b1;
      step("rst_release", 1, 1, 0, 2'd1, 8'h00, 8'h42, 0, 8'h00, 0, 0, 2'd3);
      bubble("rst_commit", 2'd1);
      chk("rst.reg1_const", rb_val, 8'h42);
      chk("rst.retired_const", retired, 8'h01);

      // Counter wrap from a fresh reset.
      #2 reset_n = 1'b0;
      #1 modelReset();
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 256; i++) begin
         step("wrap", 1, 0, 0, 2'd0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 2'd1);
      end
      chk("wrap.retired_ff", retired, 8'hFF);
      bubble("wrap_last", 2'd1);
      chk("wrap.retired_00", retired, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
